// File: rtl/pipeline_flow_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: cond codes, tag file
// fields, FSM state encoding and a small tag helper.
package pipeline_flow_ctrl_pkg;

  localparam logic [1:0] PARTS_COND_FLOW  = 2'd0;
  localparam logic [1:0] PARTS_COND_STALL = 2'd1;
  localparam logic [1:0] PARTS_COND_ZERO  = 2'd2;

  localparam logic [1:0] TAG_GPR = 2'b00;
  localparam logic [1:0] TAG_CP0 = 2'b01;
  localparam logic [1:0] TAG_HI  = 2'b10;
  localparam logic [1:0] TAG_LO  = 2'b11;

  localparam int TAG_W = 7;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } flow_state_e;

  // Tag 7'd0 is both "no operand" and GPR $0; it never creates a dependency.
  function automatic logic tag_valid(input logic [TAG_W-1:0] tag);
    return tag != '0;
  endfunction

endpackage

// File: rtl/pipeline_flow_ctrl_hazard_cmp.sv
// Combinational RAW hazard detector: flags when a live ID source tag matches
// a destination tag still in flight in EX, ME or WB.
module flow_hazard_cmp
  import pipeline_flow_ctrl_pkg::*;
(
  input  logic [TAG_W-1:0] raddr1,
  input  logic [TAG_W-1:0] raddr2,
  input  logic [TAG_W-1:0] ex_waddr,
  input  logic [TAG_W-1:0] me_waddr,
  input  logic [TAG_W-1:0] wb_waddr,
  output logic             hazard
);

  logic hit1;
  logic hit2;

  always_comb begin
    hit1 = tag_valid(raddr1) &&
           ((raddr1 == ex_waddr) || (raddr1 == me_waddr) || (raddr1 == wb_waddr));
    hit2 = tag_valid(raddr2) &&
           ((raddr2 == ex_waddr) || (raddr2 == me_waddr) || (raddr2 == wb_waddr));
    hazard = hit1 || hit2;
  end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Central 5-stage pipeline flow controller: mult/div sequencing with a
// watchdog, RAW/overflow bubbles, and stall/bubble performance counters.
module pipeline_flow_ctrl
  import pipeline_flow_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TAG_W-1:0]  id_raddr1,
  input  logic [TAG_W-1:0]  id_raddr2,
  input  logic [TAG_W-1:0]  ex_waddr,
  input  logic [TAG_W-1:0]  me_waddr,
  input  logic [TAG_W-1:0]  wb_waddr,
  input  logic              mult_div_stall,
  input  logic              cal_finish,
  input  logic              overflow_stall,
  output logic [1:0]        if_cond,
  output logic [1:0]        id_cond,
  output logic [1:0]        ex_cond,
  output logic [1:0]        me_cond,
  output logic [1:0]        wb_cond,
  output logic              md_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output flow_state_e       dbg_state
);

  localparam int MD_CNT_W = $clog2(MD_TIMEOUT + 1);

  flow_state_e         state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic                hazard;
  logic                bubble_any;

  flow_hazard_cmp u_hazard_cmp (
    .raddr1   (id_raddr1),
    .raddr2   (id_raddr2),
    .ex_waddr (ex_waddr),
    .me_waddr (me_waddr),
    .wb_waddr (wb_waddr),
    .hazard   (hazard)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;
    if_cond      = PARTS_COND_FLOW;
    id_cond      = PARTS_COND_FLOW;
    ex_cond      = PARTS_COND_FLOW;
    me_cond      = PARTS_COND_FLOW;
    wb_cond      = PARTS_COND_FLOW;

    case (state_q)
      ST_RUN: begin
        if (mult_div_stall && !cal_finish) begin
          // Freeze IF..EX around the calculator; ME takes a bubble, WB drains.
          if_cond  = PARTS_COND_STALL;
          id_cond  = PARTS_COND_STALL;
          ex_cond  = PARTS_COND_STALL;
          me_cond  = PARTS_COND_ZERO;
          state_d  = ST_MD_WAIT;
          md_cnt_d = MD_CNT_W'(1);
        end else if (overflow_stall || hazard) begin
          if_cond = PARTS_COND_STALL;
          id_cond = PARTS_COND_STALL;
          ex_cond = PARTS_COND_ZERO;
        end
      end
      ST_MD_WAIT: begin
        if (cal_finish) begin
          state_d  = ST_RUN;
          md_cnt_d = '0;
        end else if (md_cnt_q == MD_CNT_W'(MD_TIMEOUT)) begin
          // Watchdog: release the pipeline and latch the sticky error.
          state_d      = ST_RUN;
          md_cnt_d     = '0;
          md_timeout_d = 1'b1;
        end else begin
          if_cond  = PARTS_COND_STALL;
          id_cond  = PARTS_COND_STALL;
          ex_cond  = PARTS_COND_STALL;
          me_cond  = PARTS_COND_ZERO;
          md_cnt_d = md_cnt_q + MD_CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_RUN;
        md_cnt_d = '0;
      end
    endcase

    if (reset) begin
      if_cond = PARTS_COND_STALL;
      id_cond = PARTS_COND_STALL;
      ex_cond = PARTS_COND_STALL;
      me_cond = PARTS_COND_STALL;
      wb_cond = PARTS_COND_STALL;
    end

    bubble_any = (if_cond == PARTS_COND_ZERO) || (id_cond == PARTS_COND_ZERO) ||
                 (ex_cond == PARTS_COND_ZERO) || (me_cond == PARTS_COND_ZERO) ||
                 (wb_cond == PARTS_COND_ZERO);

    stall_cnt_d  = stall_cnt_q  + ((if_cond != PARTS_COND_FLOW) ? CNT_W'(1) : CNT_W'(0));
    bubble_cnt_d = bubble_cnt_q + (bubble_any ? CNT_W'(1) : CNT_W'(0));
  end

  assign md_timeout = md_timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Bench for pipeline_flow_ctrl: expected stage conds queued with each
// stimulus cycle and checked at the negedge when the DUT presents them.
module tb_pipeline_flow_ctrl;
  import pipeline_flow_ctrl_pkg::*;

  localparam int CNT_W = 32;
  localparam int MD_TIMEOUT = 40;

  localparam logic [9:0] C_FLOW  = 10'b00_00_00_00_00;
  localparam logic [9:0] C_MD    = 10'b01_01_01_10_00;
  localparam logic [9:0] C_HZ    = 10'b01_01_10_00_00;
  localparam logic [9:0] C_RESET = 10'b01_01_01_01_01;

  logic             clk;
  logic             rst;
  logic [6:0]       id_raddr1, id_raddr2, ex_waddr, me_waddr, wb_waddr;
  logic             mult_div_stall, cal_finish, overflow_stall;
  logic [1:0]       if_cond, id_cond, ex_cond, me_cond, wb_cond;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  flow_state_e      dbg_state;

  logic [9:0]       exp_q[$];
  int               tests_run;
  int               tests_failed;
  int               m_stall;
  int               m_bubble;

  pipeline_flow_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (rst),
    .id_raddr1      (id_raddr1),
    .id_raddr2      (id_raddr2),
    .ex_waddr       (ex_waddr),
    .me_waddr       (me_waddr),
    .wb_waddr       (wb_waddr),
    .mult_div_stall (mult_div_stall),
    .cal_finish     (cal_finish),
    .overflow_stall (overflow_stall),
    .if_cond        (if_cond),
    .id_cond        (id_cond),
    .ex_cond        (ex_cond),
    .me_cond        (me_cond),
    .wb_cond        (wb_cond),
    .md_timeout     (md_timeout),
    .stall_cnt      (stall_cnt),
    .bubble_cnt     (bubble_cnt),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic set_tags(input logic [6:0] r1, input logic [6:0] r2,
                          input logic [6:0] ex, input logic [6:0] me, input logic [6:0] wb);
    id_raddr1 = r1; id_raddr2 = r2; ex_waddr = ex; me_waddr = me; wb_waddr = wb;
  endtask

  task automatic set_ctrl(input logic mds, input logic cf, input logic ovf);
    mult_div_stall = mds; cal_finish = cf; overflow_stall = ovf;
  endtask

  // Scoreboard: pop one expectation at the negedge, then advance to the next
  // driving point just after the posedge.
  task automatic tick(input string name);
    logic [9:0] exp_v;
    logic [9:0] obs_v;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {if_cond, id_cond, ex_cond, me_cond, wb_cond};
      tests_run++;
      if (obs_v !== exp_v) begin
        tests_failed++;
        $display("FAIL %s conds: got %b required %b at %0t", name, obs_v, exp_v, $time);
      end
      if (!rst) begin
        if (exp_v[9:8] != 2'd0) m_stall++;
        if (exp_v[9:8] == 2'd2 || exp_v[7:6] == 2'd2 || exp_v[5:4] == 2'd2 ||
            exp_v[3:2] == 2'd2 || exp_v[1:0] == 2'd2) m_bubble++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_tags(7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    set_ctrl(1'b0, 1'b0, 1'b0);
    m_stall = 0; m_bubble = 0;
    #12;
    tests_run++;
    if ({if_cond, id_cond, ex_cond, me_cond, wb_cond} !== C_RESET) begin
      tests_failed++;
      $display("FAIL reset_conds: got %b required %b",
               {if_cond, id_cond, ex_cond, me_cond, wb_cond}, C_RESET);
    end
    tests_run++;
    if (stall_cnt !== '0 || bubble_cnt !== '0 || md_timeout !== 1'b0 || dbg_state !== ST_RUN) begin
      tests_failed++;
      $display("FAIL reset_state: got stall=%0d bubble=%0d to=%b st=%0d required 0 0 0 0",
               stall_cnt, bubble_cnt, md_timeout, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(C_FLOW);
    tick("reset_release");
  endtask

  task automatic test_hazard();
    set_tags(7'd8, 7'd0, 7'd8, 7'd0, 7'd0);
    exp_q.push_back(C_HZ);
    tick("hazard_ex");
    set_tags(7'd8, 7'd0, 7'd0, 7'd8, 7'd0);
    exp_q.push_back(C_HZ);
    tick("hazard_me");
    set_tags(7'd8, 7'd9, 7'd10, 7'd11, 7'd12);
    exp_q.push_back(C_FLOW);
    tick("hazard_distinct");
    tests_run++;
    if (stall_cnt !== CNT_W'(m_stall) || bubble_cnt !== CNT_W'(m_bubble)) begin
      tests_failed++;
      $display("FAIL hazard_counters: got %0d/%0d required %0d/%0d",
               stall_cnt, bubble_cnt, m_stall, m_bubble);
    end
  endtask

  task automatic test_zero_tag();
    logic [6:0] r1, r2, ex, me, wb;
    logic       hz;
    set_tags(7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    exp_q.push_back(C_FLOW);
    tick("zero_tag_flow");
    set_tags(7'd0, 7'h48, 7'd0, 7'd0, 7'h48);
    exp_q.push_back(C_HZ);
    tick("zero_tag_hi");
    for (int i = 0; i < 16; i++) begin
      r1 = 7'($urandom_range(0, 3)); r2 = 7'($urandom_range(0, 3));
      ex = 7'($urandom_range(0, 3)); me = 7'($urandom_range(0, 3));
      wb = 7'($urandom_range(0, 3));
      hz = (r1 != 0 && (r1 == ex || r1 == me || r1 == wb)) ||
           (r2 != 0 && (r2 == ex || r2 == me || r2 == wb));
      set_tags(r1, r2, ex, me, wb);
      exp_q.push_back(hz ? C_HZ : C_FLOW);
      tick("random_tags");
    end
    set_tags(7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
  endtask

  task automatic test_mult_div();
    int s0, b0;
    s0 = m_stall; b0 = m_bubble;
    set_ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(C_MD);
      tick("md_wait");
    end
    set_ctrl(1'b1, 1'b1, 1'b0);
    exp_q.push_back(C_FLOW);
    tick("md_finish");
    tests_run++;
    if (dbg_state !== ST_RUN || stall_cnt !== CNT_W'(s0 + 32) || bubble_cnt !== CNT_W'(b0 + 32)) begin
      tests_failed++;
      $display("FAIL md_counters: got st=%0d %0d/%0d required 0 %0d/%0d",
               dbg_state, stall_cnt, bubble_cnt, s0 + 32, b0 + 32);
    end
    // back-to-back: a new mult/div enters right after the FLOW cycle
    set_ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(C_MD);
      tick("md_back_to_back");
    end
    set_ctrl(1'b0, 1'b1, 1'b0);
    exp_q.push_back(C_FLOW);
    tick("md_b2b_finish");
    set_ctrl(1'b1, 1'b1, 1'b0);
    exp_q.push_back(C_FLOW);
    tick("md_both_in_run");
    set_ctrl(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int b0;
    b0 = m_bubble;
    set_tags(7'd5, 7'd0, 7'd5, 7'd0, 7'd0);
    set_ctrl(1'b0, 1'b0, 1'b1);
    exp_q.push_back(C_HZ);
    tick("ovf_hazard");
    tests_run++;
    if (bubble_cnt !== CNT_W'(b0 + 1)) begin
      tests_failed++;
      $display("FAIL ovf_bubble: got %0d required %0d", bubble_cnt, b0 + 1);
    end
    set_ctrl(1'b1, 1'b0, 1'b1);
    exp_q.push_back(C_MD);
    tick("ovf_vs_md");
    tests_run++;
    if (dbg_state !== ST_MD_WAIT) begin
      tests_failed++;
      $display("FAIL ovf_md_state: got %0d required %0d", dbg_state, ST_MD_WAIT);
    end
    exp_q.push_back(C_MD);
    tick("md_ignores_ovf");
    set_ctrl(1'b1, 1'b1, 1'b0);
    exp_q.push_back(C_FLOW);
    tick("ovf_md_finish");
    set_tags(7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    set_ctrl(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_watchdog();
    set_ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MD_TIMEOUT; i++) begin
      exp_q.push_back(C_MD);
      tick("wd_wait");
    end
    tests_run++;
    if (md_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_early: got %b required 0", md_timeout);
    end
    exp_q.push_back(C_FLOW);
    tick("wd_release");
    tests_run++;
    if (md_timeout !== 1'b1 || dbg_state !== ST_RUN) begin
      tests_failed++;
      $display("FAIL wd_flag: got to=%b st=%0d required 1 0", md_timeout, dbg_state);
    end
    set_ctrl(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(C_FLOW);
      tick("wd_after");
    end
    tests_run++;
    if (md_timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL wd_sticky: got %b required 1", md_timeout);
    end
  endtask

  task automatic test_reset_mid_md();
    set_ctrl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(C_MD);
      tick("rst_md_wait");
    end
    #2;
    rst = 1'b1;
    m_stall = 0; m_bubble = 0;
    #1;
    tests_run++;
    if ({if_cond, id_cond, ex_cond, me_cond, wb_cond} !== C_RESET ||
        stall_cnt !== '0 || bubble_cnt !== '0 || md_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_md: got %b %0d/%0d to=%b required %b 0/0 0",
               {if_cond, id_cond, ex_cond, me_cond, wb_cond}, stall_cnt, bubble_cnt,
               md_timeout, C_RESET);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (dbg_state !== ST_RUN) begin
      tests_failed++;
      $display("FAIL rst_state: got %0d required %0d", dbg_state, ST_RUN);
    end
    exp_q.push_back(C_FLOW);
    tick("rst_release_flow");
    tests_run++;
    if (stall_cnt !== CNT_W'(m_stall) || bubble_cnt !== CNT_W'(m_bubble)) begin
      tests_failed++;
      $display("FAIL rst_counters: got %0d/%0d required %0d/%0d",
               stall_cnt, bubble_cnt, m_stall, m_bubble);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_hazard();
    test_zero_tag();
    test_mult_div();
    test_overflow();
    test_watchdog();
    test_reset_mid_md();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: got %0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_flow_ctrl.md
Name: pipeline_flow_ctrl

Overview:
Central flow controller for the 5-stage pipeline (IF/ID/EX/ME/WB). Each cycle it drives the per-stage cond code (FLOW/STALL/ZERO) from four inputs: the stage read/write-address tags, the EX mult/div busy and finish flags, and the EX overflow flag.
- Sequences multi-cycle mult/div through a small FSM with a timeout watchdog.
- Inserts bubbles for RAW hazards and overflow squashes.
- Keeps stall and bubble performance counters.

Parameters:
MD_TIMEOUT, 40, max cycles in MD_WAIT before forced release (calculator needs 32 cycles plus margin)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  pipeline clock; state updates on posedge
reset  in  1  asynchronous, active-high
id_raddr1  in  7  ID source tag 1, {file[1:0],idx[4:0]}; file 00=GPR, 01=CP0, 10=HI, 11=LO; 7'd0 = none
id_raddr2  in  7  ID source tag 2, same encoding
ex_waddr  in  7  EX destination tag, same encoding
me_waddr  in  7  ME destination tag, same encoding
wb_waddr  in  7  WB destination tag, same encoding
mult_div_stall  in  1  EX holds a mult/div (calculator enabled)
cal_finish  in  1  calculator result valid this cycle
overflow_stall  in  1  EX instruction overflowed and must be squashed
if_cond, id_cond, ex_cond, me_cond, wb_cond  out  2 each  stage cond codes
md_timeout  out  1  sticky error: mult/div watchdog expired
stall_cnt  out  CNT_W  cycles with if_cond != FLOW
bubble_cnt  out  CNT_W  cycles in which a bubble (ZERO) was injected into any stage

Behaviour:
- Cond encoding lives in the shared header: FLOW=2'd0, STALL=2'd1, ZERO=2'd2.
- Cond outputs are combinational from registered state plus current inputs. Latency is 0; they settle before the negedge flow update.
- Reset (async):
  - state=RUN, md_cnt=0, md_timeout=0, stall_cnt=0, bubble_cnt=0.
  - While reset is high, all conds=STALL.
- FSM states: RUN, MD_WAIT.
- RUN priority, first match wins:
  1. mult_div_stall=1 and cal_finish=0: next state MD_WAIT, md_cnt←1. Conds this cycle: if/id/ex=STALL, me=ZERO, wb=FLOW.
  2. overflow_stall=1: if/id=STALL, ex=ZERO, me/wb=FLOW. The overflowing instruction is replaced by a bubble; ID re-presents next cycle.
  3. Hazard: if/id=STALL, ex=ZERO, me/wb=FLOW.
     - Hazard means any nonzero id_raddrN equals a nonzero ex_waddr, me_waddr or wb_waddr.
     - Tag 7'd0 (GPR $0 or none) never matches.
  4. Otherwise all FLOW.
- MD_WAIT:
  - cal_finish=1: all FLOW, next state RUN, md_cnt←0.
  - md_cnt==MD_TIMEOUT: all FLOW, md_timeout←1, next state RUN.
  - Otherwise: if/id/ex=STALL, me=ZERO, wb=FLOW, md_cnt←md_cnt+1.
  - Overflow and hazards are ignored in MD_WAIT; EX is frozen, so no new tags appear.
- Back-to-back mult/div: after the FLOW cycle, a new EX mult/div re-enters MD_WAIT through RUN rule 1 with no extra gap.
- cal_finish and mult_div_stall both set in RUN: treated as finished, all FLOW.
- Counters:
  - Increment on posedge; wrap modulo 2^CNT_W silently.
  - bubble_cnt counts at most 1 per cycle.
- Reset mid-MD_WAIT returns to RUN immediately and clears md_cnt. md_timeout clears only on reset.

Decomposition:
- Shared define header: PARTS_COND_* codes, the tag file-field constants (TAG_GPR/CP0/HI/LO), and the FSM state constants.
- One sub-module, flow_hazard_cmp: purely combinational.
  - Inputs: two read tags and three write tags.
  - Output: the hazard bit, with the zero-tag exclusion.
- FSM, watchdog and counters stay in the top.

Test Plan:
- RAW hazard: id_raddr1=7'd8, ex_waddr=7'd8, others 0 → if/id=1, ex=2, me/wb=0. Next cycle ex_waddr=0, me_waddr=7'd8 → same conds. With all tags distinct → all 0.
- Zero tag: id_raddr1=0, ex_waddr=0 → all FLOW. id_raddr2=7'h48 (HI) vs wb_waddr=7'h48 → stall.
- Mult/div: mult_div_stall=1 for 32 cycles, cal_finish=1 on cycle 33 → 32 cycles of {1,1,1,2,0}, then all 0, state RUN; stall_cnt=32, bubble_cnt=32.
- Watchdog: mult_div_stall=1, cal_finish never set → after MD_TIMEOUT(40) counted cycles all conds 0, md_timeout=1 and stays 1 until reset.
- Overflow with a simultaneous hazard: overflow_stall=1 and a matching tag → {1,1,2,0,0} for one cycle, bubble_cnt+1. With mult_div_stall also 1 → MD_WAIT path wins.
- Async reset asserted mid-MD_WAIT → all conds=1 immediately, counters=0; after release, state=RUN.
